rtc_sweep_sequencer: RTL and testbench
======================================

# rtc_sweep_sequencer

Upstream of the register-memory stage: walks the nine RTC registers (clock, date, timer) through a byte-wide bus driver. It periodically reads all nine and presents each byte on its `rtc_*` output with a one-cycle chip-select strobe, so the register memory latches it. On request, it writes the user-edited `count_*` values back to the RTC as one atomic sweep.

## Interface
- `READ_PERIOD`, default 1_000_000: clock cycles between read-sweep starts, measured start-to-start.
- `TIMEOUT`, default 255: maximum cycles to wait for `bus_done` after `bus_start`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock; all state is cleared on the `clk` edge where `reset`=1.
- `write_req`  in  1  one-cycle pulse: write `count_*` to the RTC.
- `count_seg_hora`, `count_min_hora`, `count_hora_hora`, `count_dia_fecha`, `count_mes_fecha`, `count_jahr_fecha`, `count_seg_timer`, `count_min_timer`, `count_hora_timer`  in  8 each  edited values.
- `bus_done`  in  1  one-cycle pulse from the bus driver; transaction complete.
- `bus_rdata`  in  8  read data; valid only in the `bus_done` cycle.
- `bus_start`  out  1  one-cycle transaction request.
- `bus_write`  out  1  1 = write, 0 = read; held from `bus_start` until `bus_done` or abort.
- `bus_addr`  out  8  RTC register address; held like `bus_write`.
- `bus_wdata`  out  8  write data; held like `bus_write`.
- `rtc_seg_hora` … `rtc_hora_timer` (the nine, same order as `count_*`)  out  8 each  last byte read per register.
- `cs_seg_hora` … `cs_hora_timer`  out  1 each  one-cycle strobe, coincident with the matching `rtc_*` update.
- `busy`  out  1  high whenever the state is not IDLE.
- `bus_error`  out  1  sticky timeout flag; cleared only by `reset`.

## Operation
- Register index 0..8 maps to addresses 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43, in the port order above.
- States:
  - **IDLE**
    - Write takes priority: if write is pending, snapshot all nine `count_*` into internal registers and go to ISSUE with write mode and index 0.
    - Otherwise, when the period counter reaches `READ_PERIOD`-1, go to ISSUE with read mode and index 0.
  - **ISSUE**: assert `bus_start` for one cycle, then go to WAIT.
  - **WAIT**
    - On `bus_done`:
      - Read mode: latch `bus_rdata` into `rtc_[index]` and pulse `cs_[index]`.
      - Then go to NEXT.
    - If the wait counter reaches `TIMEOUT` first: set `bus_error`, leave `rtc_[index]` unchanged, and go to NEXT with no strobe.
  - **NEXT**: if index = 8, go to IDLE; otherwise increment index and go to ISSUE.
- A write sweep drives `bus_wdata` from the snapshot, never from live `count_*`. It produces no `cs_*` strobes.
- `write_req` arriving during any sweep sets a pending flag that is cleared when its write sweep starts.
  - Multiple requests before service collapse into one.
  - A read sweep in progress always completes first.
- The period counter runs freely and wraps at `READ_PERIOD`-1.
  - A read start that becomes due during a sweep is deferred to IDLE: at most one deferred read is held and is taken immediately on return.
- A `bus_done` arriving outside WAIT is ignored.

## Timing
- Reset values: every output is 0, the state is IDLE, all counters are 0, and the pending flags are clear.
- `reset` mid-sweep:
  - The next cycle shows `bus_start`=0 and `busy`=0.
  - A partial sweep is abandoned and is not resumed.
  - A write request pending at reset is discarded.
- `bus_start` is asserted one cycle after entering ISSUE. For a write request serviced from IDLE, this is 2 cycles after the `write_req` cycle.
- For a `bus_done` sampled at edge N, `rtc_x` and `cs_x` are both valid after edge N+1 and `cs_x` is low again after N+2.
- The next `bus_start` follows `bus_done` by 3 cycles (WAIT→NEXT→ISSUE→pulse).
- `cs_*` is one-hot or all zero in every cycle.

## Test plan
- **Reset:** hold `reset` for 3 cycles with `write_req`=1 → all outputs 0; no `bus_start` within 5 cycles after release.
- **Read sweep:** `READ_PERIOD`=50; driver returns `bus_done` 4 cycles after each `bus_start`, with `bus_rdata`=address+1 → addresses 0x21..0x43 in order; `rtc_seg_hora`=0x22 … `rtc_hora_timer`=0x44; nine single-cycle strobes, each coincident with its data; `busy` falls after index 8.
- **Write sweep:** `count_*`=0x10..0x18; pulse `write_req`; change `count_*` to 0xFF after 1 cycle → nine writes carry 0x10..0x18 to 0x21..0x43; no `cs_*`; `rtc_*` unchanged.
- **Collision:** `write_req` ×3 during a read sweep → the read completes; exactly one write sweep follows; next read sweep follows per the deferred-read rule.
- **Timeout:** the driver never answers at address 0x24 → `bus_error`=1 after `TIMEOUT` cycles; `rtc_dia_fecha` keeps its old value; the sweep continues at 0x25; the flag stays set.
- **Mid-sweep reset:** reset during WAIT at index 4 → idle next cycle; the next read sweep restarts at 0x21.

Source files
------------

// File: rtl/rtc_sweep_sequencer_if.sv
// rtc_sweep_sequencer_if: byte-wide RTC bus between the sweep sequencer and the bus driver
interface rtc_sweep_sequencer_if;
  logic       bus_start;
  logic       bus_write;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_done;
  logic [7:0] bus_rdata;
  modport master (output bus_start, bus_write, bus_addr, bus_wdata, input bus_done, bus_rdata);
  modport slave (input bus_start, bus_write, bus_addr, bus_wdata, output bus_done, bus_rdata);
endinterface

// File: rtl/rtc_sweep_sequencer.sv
// rtc_sweep_sequencer: periodic read sweep and on-demand write sweep of the nine RTC registers
module rtc_sweep_sequencer #(
  parameter int READ_PERIOD = 1_000_000,
  parameter int TIMEOUT     = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic write_req,
  input  logic [7:0] count_seg_hora, count_min_hora, count_hora_hora,
  input  logic [7:0] count_dia_fecha, count_mes_fecha, count_jahr_fecha,
  input  logic [7:0] count_seg_timer, count_min_timer, count_hora_timer,
  rtc_sweep_sequencer_if.master bus,
  output logic [7:0] rtc_seg_hora, rtc_min_hora, rtc_hora_hora,
  output logic [7:0] rtc_dia_fecha, rtc_mes_fecha, rtc_jahr_fecha,
  output logic [7:0] rtc_seg_timer, rtc_min_timer, rtc_hora_timer,
  output logic cs_seg_hora, cs_min_hora, cs_hora_hora,
  output logic cs_dia_fecha, cs_mes_fecha, cs_jahr_fecha,
  output logic cs_seg_timer, cs_min_timer, cs_hora_timer,
  output logic busy,
  output logic bus_error
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;
  localparam int PW = $clog2(READ_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic wr_q, wr_d, wpend_q, wpend_d, rpend_q, rpend_d, got_q, got_d;
  logic start_q, start_d, bwrite_q, bwrite_d, err_q, err_d, due;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [7:0] rd_q, rd_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [8:0][7:0] cnt, snap_q, snap_d, rtc_q, rtc_d;
  logic [8:0] cs_q, cs_d;
  assign cnt = {count_hora_timer, count_min_timer, count_seg_timer, count_jahr_fecha,
                count_mes_fecha, count_dia_fecha, count_hora_hora, count_min_hora, count_seg_hora};
  assign {rtc_hora_timer, rtc_min_timer, rtc_seg_timer, rtc_jahr_fecha, rtc_mes_fecha,
          rtc_dia_fecha, rtc_hora_hora, rtc_min_hora, rtc_seg_hora} = rtc_q;
  assign {cs_hora_timer, cs_min_timer, cs_seg_timer, cs_jahr_fecha, cs_mes_fecha,
          cs_dia_fecha, cs_hora_hora, cs_min_hora, cs_seg_hora} = cs_q;
  assign bus.bus_start = start_q;
  assign bus.bus_write = bwrite_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign busy          = state_q != IDLE;
  assign bus_error     = err_q;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    got_d    = got_q;
    rd_d     = rd_q;
    snap_d   = snap_q;
    rtc_d    = rtc_q;
    wait_d   = wait_q;
    bwrite_d = bwrite_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    start_d  = 1'b0;
    cs_d     = '0;
    due      = per_q == PW'(READ_PERIOD - 1);
    per_d    = due ? '0 : per_q + PW'(1);
    // requests seen while busy are remembered; IDLE consumes them
    wpend_d  = wpend_q | write_req;
    rpend_d  = rpend_q | due;
    case (state_q)
      IDLE:
        if (wpend_q | write_req) begin
          state_d = ISSUE;
          wr_d    = 1'b1;
          idx_d   = '0;
          snap_d  = cnt;
          wpend_d = 1'b0;
        end else if (rpend_q | due) begin
          state_d = ISSUE;
          wr_d    = 1'b0;
          idx_d   = '0;
          rpend_d = 1'b0;
        end
      ISSUE: begin
        state_d  = WAIT;
        start_d  = 1'b1;
        wait_d   = '0;
        bwrite_d = wr_q;
        addr_d   = idx_q < 4'd6 ? 8'h21 + {4'd0, idx_q} : 8'h3B + {4'd0, idx_q};
        wdata_d  = wr_q ? snap_q[idx_q] : 8'h00;
      end
      WAIT:
        if (bus.bus_done) begin
          state_d = NEXT;
          got_d   = !wr_q;
          rd_d    = bus.bus_rdata;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          state_d = NEXT;
          got_d   = 1'b0;
          err_d   = 1'b1;
        end else
          wait_d = wait_q + TW'(1);
      NEXT: begin
        if (got_q) begin
          rtc_d[idx_q] = rd_q;
          cs_d[idx_q]  = 1'b1;
        end
        state_d = idx_q == 4'd8 ? IDLE : ISSUE;
        idx_d   = idx_q == 4'd8 ? idx_q : idx_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wpend_q  <= 1'b0;
      rpend_q  <= 1'b0;
      got_q    <= 1'b0;
      start_q  <= 1'b0;
      bwrite_q <= 1'b0;
      err_q    <= 1'b0;
      per_q    <= '0;
      wait_q   <= '0;
      rd_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      snap_q   <= '0;
      rtc_q    <= '0;
      cs_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      wpend_q  <= wpend_d;
      rpend_q  <= rpend_d;
      got_q    <= got_d;
      start_q  <= start_d;
      bwrite_q <= bwrite_d;
      err_q    <= err_d;
      per_q    <= per_d;
      wait_q   <= wait_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      snap_q   <= snap_d;
      rtc_q    <= rtc_d;
      cs_q     <= cs_d;
    end
endmodule

// File: tb/tb_rtc_sweep_sequencer.sv
// tb_rtc_sweep_sequencer: directed scenarios, a bus-driver responder and a per-cycle sweep model
module tb_rtc_sweep_sequencer;
  localparam int P = 50, TO = 20;
  logic clk = 0, reset = 1, write_req = 0;
  logic [7:0] cnt [9];
  logic [7:0] rtc [9];
  logic [8:0] cs;
  logic busy, bus_error;
  logic [7:0] amap [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  rtc_sweep_sequencer_if bus ();
  rtc_sweep_sequencer #(.READ_PERIOD(P), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .write_req(write_req),
    .count_seg_hora(cnt[0]), .count_min_hora(cnt[1]), .count_hora_hora(cnt[2]),
    .count_dia_fecha(cnt[3]), .count_mes_fecha(cnt[4]), .count_jahr_fecha(cnt[5]),
    .count_seg_timer(cnt[6]), .count_min_timer(cnt[7]), .count_hora_timer(cnt[8]),
    .bus(bus),
    .rtc_seg_hora(rtc[0]), .rtc_min_hora(rtc[1]), .rtc_hora_hora(rtc[2]),
    .rtc_dia_fecha(rtc[3]), .rtc_mes_fecha(rtc[4]), .rtc_jahr_fecha(rtc[5]),
    .rtc_seg_timer(rtc[6]), .rtc_min_timer(rtc[7]), .rtc_hora_timer(rtc[8]),
    .cs_seg_hora(cs[0]), .cs_min_hora(cs[1]), .cs_hora_hora(cs[2]),
    .cs_dia_fecha(cs[3]), .cs_mes_fecha(cs[4]), .cs_jahr_fecha(cs[5]),
    .cs_seg_timer(cs[6]), .cs_min_timer(cs[7]), .cs_hora_timer(cs[8]),
    .busy(busy), .bus_error(bus_error)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  bit chk_en = 0;
  int cs_cnt [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a sweep is a run of nine transactions; a bus_start lands two edges after a
  // sweep is chosen and three after the previous completion; busy drops two edges after
  // the last completion; each read completion shows up as data+strobe one edge later.
  bit m_on, m_wait, m_kind, m_end, m_csp, wp, rp, m_idle, m_due;
  int m_cd, m_wt, m_idx, m_csi, per;
  logic [7:0] m_csd, snap [9];
  logic e_start, e_write, e_err;
  logic [7:0] e_addr, e_wdata, e_rtc [9];
  logic [8:0] e_cs;
  initial forever begin
    @(posedge clk);
    if (reset) begin
      {m_on, m_wait, m_kind, m_end, m_csp, wp, rp} = '0;
      m_cd = 0; m_wt = 0; m_idx = 0; per = 0;
      {e_start, e_write, e_err, e_addr, e_wdata, e_cs} = '0;
      for (int i = 0; i < 9; i++) e_rtc[i] = 8'h00;
    end else begin
      m_idle = !m_on;
      m_due = per == P - 1;
      per = m_due ? 0 : per + 1;
      e_start = 0;
      e_cs = '0;
      if (m_csp) begin
        e_rtc[m_csi] = m_csd;
        e_cs[m_csi] = 1'b1;
        m_csp = 0;
      end
      if (m_end) begin
        m_on = 0;
        m_end = 0;
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          e_start = 1;
          e_addr = amap[m_idx];
          e_write = m_kind;
          e_wdata = m_kind ? snap[m_idx] : 8'h00;
          m_wait = 1;
          m_wt = 0;
        end
      end else if (m_wait) begin
        if (bus.bus_done === 1'b1 || m_wt == TO - 1) begin
          m_wait = 0;
          if (bus.bus_done !== 1'b1) e_err = 1;
          else if (!m_kind) begin
            m_csp = 1;
            m_csi = m_idx;
            m_csd = bus.bus_rdata;
          end
          if (m_idx == 8) m_end = 1;
          else begin
            m_idx++;
            m_cd = 2;
          end
        end else m_wt++;
      end
      if (m_idle) begin
        if (wp || write_req) begin
          m_on = 1; m_kind = 1; m_idx = 0; m_cd = 1; wp = 0;
          for (int i = 0; i < 9; i++) snap[i] = cnt[i];
          if (m_due) rp = 1;
        end else if (rp || m_due) begin
          m_on = 1; m_kind = 0; m_idx = 0; m_cd = 1; rp = 0;
        end
      end else begin
        if (write_req) wp = 1;
        if (m_due) rp = 1;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("bus_start", bus.bus_start, e_start);
      chk("busy", busy, m_on);
      chk("bus_error", bus_error, e_err);
      chk("bus_addr", bus.bus_addr, e_addr);
      chk("bus_write", bus.bus_write, e_write);
      if (e_write) chk("bus_wdata", bus.bus_wdata, e_wdata);
      chk("cs", cs, e_cs);
      chk("cs_onehot", $onehot0(cs), 1);
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("rtc%0d", i), rtc[i], e_rtc[i]);
        if (cs[i] === 1'b1) cs_cnt[i]++;
      end
    end
  end
  bit silent = 0;
  time done_t = 0;
  int wr_cnt = 0;
  logic [7:0] last_rd = 8'h00, r_a;
  initial begin
    bus.bus_done = 0;
    bus.bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.bus_start === 1'b1) begin
        if (bus.bus_write) wr_cnt++;
        else last_rd = bus.bus_addr;
        if (!(silent && bus.bus_addr == 8'h24)) begin
          r_a = bus.bus_addr;
          repeat (4) @(negedge clk);
          bus.bus_done = 1;
          bus.bus_rdata = r_a + 8'd1;
          done_t = $time;
          @(negedge clk);
          bus.bus_done = 0;
        end
      end
    end
  end
  task automatic wait_start(input logic [7:0] a, input logic w, input int lim, input string nm);
    bit f = 0;
    for (int n = 0; n < lim && !f; n++) begin
      @(negedge clk);
      f = bus.bus_start === 1'b1 && bus.bus_addr === a && bus.bus_write === w;
    end
    chk(nm, f, 1);
  endtask
  initial begin
    bit f;
    time t0;
    for (int i = 0; i < 9; i++) begin cnt[i] = 8'h00; cs_cnt[i] = 0; end
    reset = 1; write_req = 1;
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_start", bus.bus_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", bus_error, 0);
    chk("rst_cs", cs, 0);
    chk("rst_addr", {bus.bus_write, bus.bus_addr, bus.bus_wdata}, 0);
    chk("rst_rtc", {rtc[0], rtc[1], rtc[2], rtc[3]} | {rtc[4], rtc[5], rtc[6], rtc[7]} | {24'd0, rtc[8]}, 0);
    reset = 0; write_req = 0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_start", bus.bus_start, 0);
    end
    // write sweep uses the snapshot, not the live counts
    for (int i = 0; i < 9; i++) cnt[i] = 8'h10 + 8'(i);
    write_req = 1;
    @(negedge clk);
    write_req = 0;
    for (int i = 0; i < 9; i++) cnt[i] = 8'hFF;
    @(negedge clk);
    chk("wr_latency", bus.bus_start, 1);
    chk("wr_first", {bus.bus_write, bus.bus_addr, bus.bus_wdata}, 17'h12110);
    for (int i = 1; i < 9; i++) begin
      wait_start(amap[i], 1, 20, "wr_next");
      chk("wr_wdata", bus.bus_wdata, 8'h10 + 8'(i));
      chk("wr_gap", int'(($time - done_t) / 10), 3);
    end
    // period expired during the write sweep: deferred read follows at once
    wait_start(8'h21, 0, 30, "rd_deferred");
    chk("rd_defer_gap", int'(($time - done_t) / 10), 4);
    for (int i = 1; i < 9; i++) wait_start(amap[i], 0, 20, "rd_order");
    repeat (6) @(negedge clk);
    chk("rd_cs_last", cs, 9'h100);
    chk("rd_seg_hora", rtc[0], 8'h22);
    chk("rd_jahr_fecha", rtc[5], 8'h27);
    chk("rd_seg_timer", rtc[6], 8'h42);
    chk("rd_hora_timer", rtc[8], 8'h44);
    @(negedge clk);
    chk("rd_cs_low", cs, 0);
    for (int i = 0; i < 9; i++) chk($sformatf("rd_cs_count%0d", i), cs_cnt[i], 1);
    // collision: three requests during a read collapse into one write sweep
    wait_start(8'h22, 0, 200, "col_rd");
    repeat (3) begin
      write_req = 1;
      @(negedge clk);
      write_req = 0;
      repeat (4) @(negedge clk);
    end
    wait_start(8'h21, 1, 200, "col_wr_start");
    chk("col_rd_first", last_rd, 8'h43);
    wait_start(8'h21, 0, 200, "col_rd_after");
    chk("col_rd_gap", int'(($time - done_t) / 10), 4);
    chk("col_one_write", wr_cnt, 18);
    // timeout at 0x24
    silent = 1;
    wait_start(8'h24, 0, 60, "to_start");
    t0 = $time;
    f = 0;
    for (int n = 0; n < 60 && !f; n++) begin
      @(negedge clk);
      f = bus_error === 1'b1;
    end
    chk("to_seen", f, 1);
    chk("to_latency", int'(($time - t0) / 10), TO);
    chk("to_keep", rtc[3], 8'h25);
    silent = 0;
    wait_start(8'h25, 0, 10, "to_continue");
    wait_start(8'h43, 0, 80, "to_sweep_end");
    chk("to_sticky", bus_error, 1);
    // reset while waiting at index 4, with a write pending
    wait_start(8'h25, 0, 200, "mr_idx4");
    @(negedge clk);
    write_req = 1;
    @(negedge clk);
    write_req = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mr_start", bus.bus_start, 0);
    chk("mr_busy", busy, 0);
    wait_start(8'h21, 0, 80, "mr_restart");
    chk("mr_no_write", wr_cnt, 18);
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
